sram_port: RTL and testbench
============================

Name: sram_port

Overview:
- Timed access engine for the external 8-bit asynchronous SRAM (21-bit address).
- Sits between the CPU IO decode (0x4000 region) and the SRAM pins, replacing static register-driven pin control.
- Also serves a read-only video fetch port.
- Arbitrates between the two requesters and generates glitch-free, registered CE/OE/WE strobes with programmable wait states.

Parameters:
- AW, 21, SRAM address width.
- DW, 8, SRAM data width.
- WAIT, 3, cycles of active strobe per access (≥1); 3 at 80 MHz gives ≥37.5 ns pulse.

Ports:
- clk  in  1  system clock; all logic single clock domain.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  one-cycle request strobe; sampled only while cpu_busy=0.
- cpu_we  in  1  1=write, 0=read; qualified by cpu_req.
- cpu_addr  in  AW  CPU address, captured on accept.
- cpu_wdata  in  DW  CPU write data, captured on accept.
- cpu_busy  out  1  CPU request pending or in flight.
- cpu_rdata  out  DW  CPU read data; holds last read value.
- cpu_rvalid  out  1  one-cycle pulse when cpu_rdata is updated.
- vid_req  in  1  level video read request; held with vid_addr until vid_ack.
- vid_addr  in  AW  video fetch address.
- vid_ack  out  1  one-cycle pulse: vid_addr captured, requester may advance.
- vid_rdata  out  DW  video read data.
- vid_rvalid  out  1  one-cycle pulse when vid_rdata is updated.
- sram_addr  out  AW  registered SRAM address.
- sram_dout  out  DW  write data toward pad.
- sram_doe  out  1  pad output enable; top level tristates sram_dout when 0.
- sram_din  in  DW  data from pad.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes, driven directly from flops.

Behaviour:
- Reset values (asynchronous, immediate):
  - all outputs inactive: ce_n/oe_n/we_n=1, doe=0;
  - sram_addr=0, sram_dout=0;
  - cpu_busy=0, cpu_rdata=0, vid_rdata=0;
  - all pulses (cpu_rvalid, vid_ack, vid_rvalid)=0.
- Reset mid-operation aborts the access; pending or in-flight requests are lost and no rvalid is issued.
- CPU accept:
  - cpu_req=1 with cpu_busy=0 latches we/addr/wdata into a pending slot.
  - cpu_busy=1 from the next cycle until the cycle the transaction's state returns to IDLE.
  - cpu_req while cpu_busy=1 is ignored.
- Video requests are presented level-sensitively and are never latched early.
- FSM states: IDLE, WSETUP, WPULSE, WHOLD, RD, TURN.
- Grant (in IDLE only):
  - If only one requester is pending, grant it.
  - If both are pending, grant video, unless the previous grant was video, in which case grant CPU (alternation).
  - Worst-case CPU start latency is (WAIT+2)+1 cycles.
- Access timeline (cycle 0 = IDLE grant cycle):
  - All pin registers load at cycle 0's edge, so cycle 1 is the first state cycle.
- Write (CPU only):
  - cycle 1 WSETUP: ce_n=0, doe=1, address and data driven, we_n=1.
  - cycles 2..WAIT+1 WPULSE: we_n=0.
  - cycle WAIT+2 WHOLD: we_n=1; ce_n, doe and data are held.
  - cycle WAIT+3: IDLE with all strobes inactive and doe=0.
- Read:
  - cycles 1..WAIT+1 RD: ce_n=0, oe_n=0, doe=0.
  - sram_din is registered at the end of cycle WAIT+1.
  - cycle WAIT+2 TURN: strobes inactive, doe=0; rdata updated and the requester's rvalid=1 for exactly this cycle.
  - IDLE at cycle WAIT+3.
- Every access occupies WAIT+2 non-IDLE cycles plus one IDLE cycle. There are no back-to-back accesses without IDLE.
- vid_ack pulses in cycle 1 of a video grant.
- Invariants:
  - doe=1 never coincides with oe_n=0.
  - we_n=0 only while ce_n=0 and doe=1.
  - Address is stable throughout every non-IDLE state.
  - A video read never disturbs cpu_rdata, and a CPU read never disturbs vid_rdata.
- Arithmetic: the wait counter is $clog2(WAIT+1) bits and reloads on each state entry; address values pass through unmodified, with no wrap logic.

Test Plan:
- Reset: assert reset mid-WPULSE → same-cycle ce_n=oe_n=we_n=1, doe=0, cpu_busy=0; no subsequent rvalid.
- CPU write, WAIT=3, addr 0x12345, data 0xA5:
  - sram_addr=0x12345 and sram_dout=0xA5, with doe=1 and ce_n=0, for cycles 1-5;
  - we_n=0 exactly in cycles 2-4;
  - cpu_busy high 6 cycles; SRAM model then holds 0xA5.
- CPU read of 0x12345 with the model returning 0xA5 after 30 ns:
  - oe_n=0 cycles 1-4;
  - cpu_rvalid pulses in cycle 5 with cpu_rdata=0xA5;
  - vid_rvalid stays 0.
- Contention:
  - vid_req held continuously (addr 0x00100, incrementing on each vid_ack), plus cpu_req read of 0x00200 → grants alternate vid/cpu;
  - cpu_rvalid arrives within 11 cycles of cpu_req;
  - vid_ack count increments by 1 per video access.
- cpu_req pulsed again while cpu_busy=1 (different addr 0x1FFFFF) → ignored: only one access occurs and sram_addr never shows 0x1FFFFF.
- Turnaround: read immediately followed by a pending write → TURN and IDLE separate oe_n rising from doe rising by ≥2 cycles; the doe/oe_n overlap checker never fires.

Source files
------------

// File: rtl/sram_port.sv
// rtl/sram_port.sv - timed CPU/video access engine for an external async SRAM
// All pin strobes come straight from flops; every access ends in one IDLE cycle.
module sram_port #(
    parameter int AW   = 21,
    parameter int DW   = 8,
    parameter int WAIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_busy,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_rvalid,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    output logic          sram_doe,
    input  logic [DW-1:0] sram_din,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    localparam int CW = $clog2(WAIT + 1);

    typedef enum logic [2:0] {IDLE, WSETUP, WPULSE, WHOLD, RD, TURN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          own_vid_q, own_vid_d;
    logic          last_vid_q, last_vid_d;
    logic          pend_q, pend_d;
    logic          pend_we_q, pend_we_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [DW-1:0] pend_wdata_q, pend_wdata_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          doe_q, doe_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic [DW-1:0] vid_rdata_q, vid_rdata_d;
    logic          vid_rvalid_q, vid_rvalid_d;
    logic          vid_ack_q, vid_ack_d;
    logic          grant_vid, grant_cpu;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        own_vid_d    = own_vid_q;
        last_vid_d   = last_vid_q;
        pend_d       = pend_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        busy_d       = busy_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        doe_d        = doe_q;
        ce_n_d       = ce_n_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_rvalid_d = 1'b0;
        vid_rdata_d  = vid_rdata_q;
        vid_rvalid_d = 1'b0;
        vid_ack_d    = 1'b0;
        grant_vid    = 1'b0;
        grant_cpu    = 1'b0;

        // A pending CPU slot always implies busy, so accept never races a grant.
        if (cpu_req && !busy_q) begin
            pend_d       = 1'b1;
            busy_d       = 1'b1;
            pend_we_d    = cpu_we;
            pend_addr_d  = cpu_addr;
            pend_wdata_d = cpu_wdata;
        end

        case (state_q)
            IDLE: begin
                grant_vid = vid_req && (!pend_q || !last_vid_q);
                grant_cpu = pend_q && !grant_vid;
                if (grant_vid) begin
                    own_vid_d  = 1'b1;
                    last_vid_d = 1'b1;
                    vid_ack_d  = 1'b1;
                    addr_d     = vid_addr;
                    state_d    = RD;
                    ce_n_d     = 1'b0;
                    oe_n_d     = 1'b0;
                    doe_d      = 1'b0;
                    cnt_d      = CW'(WAIT);
                end else if (grant_cpu) begin
                    own_vid_d  = 1'b0;
                    last_vid_d = 1'b0;
                    pend_d     = 1'b0;
                    addr_d     = pend_addr_q;
                    ce_n_d     = 1'b0;
                    if (pend_we_q) begin
                        state_d = WSETUP;
                        doe_d   = 1'b1;
                        dout_d  = pend_wdata_q;
                    end else begin
                        state_d = RD;
                        oe_n_d  = 1'b0;
                        doe_d   = 1'b0;
                        cnt_d   = CW'(WAIT);
                    end
                end
            end
            WSETUP: begin
                state_d = WPULSE;
                we_n_d  = 1'b0;
                cnt_d   = CW'(WAIT - 1);
            end
            WPULSE: begin
                if (cnt_q == '0) begin
                    state_d = WHOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WHOLD: begin
                state_d = IDLE;
                ce_n_d  = 1'b1;
                doe_d   = 1'b0;
                busy_d  = 1'b0;
            end
            RD: begin
                if (cnt_q == '0) begin
                    state_d = TURN;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    if (own_vid_q) begin
                        vid_rdata_d  = sram_din;
                        vid_rvalid_d = 1'b1;
                    end else begin
                        cpu_rdata_d  = sram_din;
                        cpu_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TURN: begin
                state_d = IDLE;
                if (!own_vid_q) begin
                    busy_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            own_vid_q    <= 1'b0;
            last_vid_q   <= 1'b0;
            pend_q       <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
            doe_q        <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            vid_rdata_q  <= '0;
            vid_rvalid_q <= 1'b0;
            vid_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            own_vid_q    <= own_vid_d;
            last_vid_q   <= last_vid_d;
            pend_q       <= pend_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            doe_q        <= doe_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_rdata_q  <= vid_rdata_d;
            vid_rvalid_q <= vid_rvalid_d;
            vid_ack_q    <= vid_ack_d;
        end
    end

    assign cpu_busy   = busy_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign vid_ack    = vid_ack_q;
    assign vid_rdata  = vid_rdata_q;
    assign vid_rvalid = vid_rvalid_q;
    assign sram_addr  = addr_q;
    assign sram_dout  = dout_q;
    assign sram_doe   = doe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_port.sv
// tb/tb_sram_port.sv - directed bench for sram_port with a behavioural SRAM model
module tb_sram_port;

    localparam int AW   = 21;
    localparam int DW   = 8;
    localparam int WAIT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_busy;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;
    logic          vid_rvalid;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout;
    logic          sram_doe;
    logic [DW-1:0] sram_din = '0;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    int checks = 0;
    int errors = 0;
    int inv_viol = 0;
    logic          prev_ce_n = 1'b1;
    logic [AW-1:0] prev_addr = '0;

    logic [7:0] mem [logic [20:0]];

    sram_port #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [20:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    // SRAM: write latches on WE rising, read data valid 30 ns after OE falls.
    always @(posedge sram_we_n) begin
        if (!sram_ce_n && sram_doe) mem[sram_addr] = sram_dout;
    end

    always begin
        @(negedge sram_oe_n);
        sram_din = 8'h00;
        #30;
        if (!sram_oe_n && !sram_ce_n) sram_din = mem_rd(sram_addr);
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (sram_doe && !sram_oe_n) inv_viol = inv_viol + 1;
            if (!sram_we_n && (sram_ce_n || !sram_doe)) inv_viol = inv_viol + 1;
            if (!sram_ce_n && !prev_ce_n && sram_addr !== prev_addr) inv_viol = inv_viol + 1;
        end
        prev_ce_n <= sram_ce_n;
        prev_addr <= sram_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_doe, cpu_busy, cpu_rvalid, vid_ack, vid_rvalid} !== 8'b1110_0000) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 11100000",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_doe, cpu_busy, cpu_rvalid, vid_ack, vid_rvalid});
        end
        checks++;
        if ({sram_addr, sram_dout, cpu_rdata, vid_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero", sram_addr, sram_dout, cpu_rdata, vid_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_write();
        int busy_cnt;
        logic exp_we;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h12345; cpu_wdata = 8'hA5;
        tick();
        cpu_req = 1'b0;
        checks++;
        if (cpu_busy !== 1'b1 || sram_ce_n !== 1'b1) begin
            errors++;
            $display("FAIL wr_c0: got busy=%b ce_n=%b expected busy=1 ce_n=1", cpu_busy, sram_ce_n);
        end
        busy_cnt = int'(cpu_busy);
        for (int c = 1; c <= 6; c++) begin
            tick();
            busy_cnt += int'(cpu_busy);
            exp_we = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            if (c <= 5) begin
                checks++;
                if ({sram_ce_n, sram_doe, sram_we_n, sram_oe_n, sram_addr, sram_dout} !== {1'b0, 1'b1, exp_we, 1'b1, 21'h12345, 8'hA5}) begin
                    errors++;
                    $display("FAIL wr_c%0d: got ce_n=%b doe=%b we_n=%b oe_n=%b addr=%h dout=%h expected 0 1 %b 1 12345 a5",
                             c, sram_ce_n, sram_doe, sram_we_n, sram_oe_n, sram_addr, sram_dout, exp_we);
                end
            end else begin
                checks++;
                if ({sram_ce_n, sram_doe, sram_we_n, cpu_busy} !== 4'b1010) begin
                    errors++;
                    $display("FAIL wr_idle: got ce_n=%b doe=%b we_n=%b busy=%b expected 1 0 1 0",
                             sram_ce_n, sram_doe, sram_we_n, cpu_busy);
                end
            end
        end
        checks++;
        if (busy_cnt != 6) begin
            errors++;
            $display("FAIL wr_busy_len: got %0d expected 6", busy_cnt);
        end
        checks++;
        if (mem_rd(21'h12345) !== 8'hA5) begin
            errors++;
            $display("FAIL wr_mem: got %h expected a5", mem_rd(21'h12345));
        end
    endtask

    task automatic test_cpu_read();
        logic exp_oe;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h12345;
        tick();
        cpu_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            exp_oe = (c <= 4) ? 1'b0 : 1'b1;
            checks++;
            if ({sram_oe_n, cpu_rvalid, vid_rvalid, sram_doe} !== {exp_oe, c == 5, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rd_c%0d: got oe_n=%b rvalid=%b vid_rvalid=%b doe=%b expected %b %b 0 0",
                         c, sram_oe_n, cpu_rvalid, vid_rvalid, sram_doe, exp_oe, c == 5);
            end
            if (c == 5) begin
                checks++;
                if (cpu_rdata !== 8'hA5) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected a5", cpu_rdata);
                end
            end
        end
        checks++;
        if (vid_rdata !== 8'h00) begin
            errors++;
            $display("FAIL rd_vid_untouched: got %h expected 00", vid_rdata);
        end
    endtask

    task automatic test_contention();
        int acks, vrv, cpu_rv_k, cpu_rv_cnt, nst;
        logic [AW-1:0] starts [8];
        logic [AW-1:0] exp_starts [5];
        logic pce;
        exp_starts = '{21'h00100, 21'h00200, 21'h00101, 21'h00102, 21'h00103};
        for (int i = 0; i < 4; i++) mem[21'h00100 + 21'(i)] = 8'h40 + 8'(i);
        mem[21'h00200] = 8'h3C;
        acks = 0; vrv = 0; cpu_rv_k = -1; cpu_rv_cnt = 0; nst = 0; pce = 1'b1;
        vid_addr = 21'h00100; vid_req = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00200;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) cpu_req = 1'b0;
            if (vid_ack) begin
                acks++;
                vid_addr = vid_addr + 21'd1;
            end
            if (cpu_rvalid) begin
                cpu_rv_cnt++;
                cpu_rv_k = k;
            end
            if (vid_rvalid) begin
                checks++;
                if (vid_rdata !== 8'h40 + 8'(vrv)) begin
                    errors++;
                    $display("FAIL ct_vdata%0d: got %h expected %h", vrv, vid_rdata, 8'h40 + 8'(vrv));
                end
                vrv++;
            end
            if (!sram_ce_n && pce) begin
                if (nst < 8) starts[nst] = sram_addr;
                nst++;
            end
            pce = sram_ce_n;
            if (k == 30) vid_req = 1'b0;
        end
        checks++;
        if (cpu_rv_k != 11 || cpu_rv_cnt != 1) begin
            errors++;
            $display("FAIL ct_cpu_lat: got cycle %0d count %0d expected cycle 11 count 1", cpu_rv_k, cpu_rv_cnt);
        end
        checks++;
        if (cpu_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL ct_cpu_data: got %h expected 3c", cpu_rdata);
        end
        checks++;
        if (acks != 4 || vrv != 4) begin
            errors++;
            $display("FAIL ct_vid_count: got acks=%0d rvalids=%0d expected 4 4", acks, vrv);
        end
        checks++;
        if (nst != 5) begin
            errors++;
            $display("FAIL ct_accesses: got %0d expected 5", nst);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (starts[i] !== exp_starts[i]) begin
                    errors++;
                    $display("FAIL ct_order%0d: got %h expected %h", i, starts[i], exp_starts[i]);
                end
            end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_busy_ignore();
        int bad, nst, rv;
        logic pce;
        bad = 0; nst = 0; rv = 0; pce = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h12345;
        tick();
        checks++;
        if (cpu_busy !== 1'b1) begin
            errors++;
            $display("FAIL bi_busy: got %b expected 1", cpu_busy);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h1FFFFF; cpu_wdata = 8'hEE;
        for (int k = 1; k <= 12; k++) begin
            tick();
            cpu_req = (k == 2 || k == 4) ? 1'b1 : 1'b0;
            if (sram_addr === 21'h1FFFFF) bad++;
            if (cpu_rvalid) rv++;
            if (!sram_ce_n && pce) nst++;
            pce = sram_ce_n;
        end
        checks++;
        if (bad != 0 || nst != 1 || rv != 1) begin
            errors++;
            $display("FAIL bi_ignored: got bad_addr=%0d accesses=%0d rvalids=%0d expected 0 1 1", bad, nst, rv);
        end
        checks++;
        if (mem.exists(21'h1FFFFF)) begin
            errors++;
            $display("FAIL bi_mem: got write to 1fffff expected none");
        end
    endtask

    task automatic test_turnaround();
        int oe_rise, doe_rise;
        logic poe, pdoe;
        oe_rise = -1; doe_rise = -1; poe = 1'b1; pdoe = 1'b0;
        mem[21'h00300] = 8'h66;
        vid_req = 1'b1; vid_addr = 21'h00300;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h00301; cpu_wdata = 8'h5A;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1) cpu_req = 1'b0;
            if (vid_ack) vid_req = 1'b0;
            if (sram_oe_n && !poe && oe_rise < 0) oe_rise = k;
            if (sram_doe && !pdoe && doe_rise < 0) doe_rise = k;
            poe = sram_oe_n;
            pdoe = sram_doe;
        end
        checks++;
        if (oe_rise != 5 || doe_rise != 7) begin
            errors++;
            $display("FAIL ta_gap: got oe_n rise %0d doe rise %0d expected 5 7", oe_rise, doe_rise);
        end
        checks++;
        if (vid_rdata !== 8'h66 || mem_rd(21'h00301) !== 8'h5A) begin
            errors++;
            $display("FAIL ta_data: got vid=%h mem=%h expected 66 5a", vid_rdata, mem_rd(21'h00301));
        end
    endtask

    task automatic test_reset_mid();
        int late;
        late = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h00400; cpu_wdata = 8'h77;
        tick();
        cpu_req = 1'b0;
        tick();
        tick();
        checks++;
        if (sram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL rm_pulse: got we_n=%b expected 0", sram_we_n);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_doe, cpu_busy} !== 5'b11100) begin
            errors++;
            $display("FAIL rm_async: got %b expected 11100",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_doe, cpu_busy});
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cpu_rvalid || vid_rvalid || !sram_ce_n || cpu_busy) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL rm_after: got %0d active cycles expected 0", late);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_contention();
        test_busy_ignore();
        test_turnaround();
        test_reset_mid();
        checks++;
        if (inv_viol != 0) begin
            errors++;
            $display("FAIL invariants: got %0d violations expected 0", inv_viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
